fifo_spi_drain: RTL

- Reader end of the byte FIFO (ufifo) in the SPI bridge.
- Pops bytes from the FIFO read port and shifts them out as an SPI master (mode 0, MSB first).
- Captures MISO in parallel and presents each received byte as a one-cycle strobe.
- Keeps CS asserted across back-to-back bytes while the FIFO stays non-empty.

---
 rtl/spi_bridge_pkg.sv | 11 +
 rtl/fifo_spi_drain_if.sv | 29 ++
 rtl/spi_clk_div.sv | 42 ++++
 rtl/fifo_spi_drain.sv | 124 ++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared SPI bridge definitions: drain FSM states, SPI mode and default word width.
package spi_bridge_pkg;

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} drain_state_t;

   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;

   localparam int DEFAULT_DW = 8;

endpackage

// File: rtl/fifo_spi_drain_if.sv
// FIFO read port plus SPI pins of the drain; master is the drain, slave the FIFO/SPI side.
interface fifo_spi_drain_if
   import spi_bridge_pkg::*;
#(
   parameter int DW = DEFAULT_DW
) ();

   logic          i_fifo_empty;
   logic [DW-1:0] i_fifo_data;
   logic          o_fifo_rd;
   logic          o_cs_n;
   logic          o_sck;
   logic          o_mosi;
   logic          i_miso;
   logic [DW-1:0] o_rx_data;
   logic          o_rx_valid;
   logic          o_busy;

   modport master (
      input  i_fifo_empty, i_fifo_data, i_miso,
      output o_fifo_rd, o_cs_n, o_sck, o_mosi, o_rx_data, o_rx_valid, o_busy
   );

   modport slave (
      output i_fifo_empty, i_fifo_data, i_miso,
      input  o_fifo_rd, o_cs_n, o_sck, o_mosi, o_rx_data, o_rx_valid, o_busy
   );

endinterface

// File: rtl/spi_clk_div.sv
// SCK half-period divider: tick every CLK_DIV enabled cycles; rise/fall alternate while sck_en.
// Counter and phase clear whenever the divider is disabled.
module spi_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sck_en,
   output logic tick,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          phase;

   assign tick = en && (cnt == LAST);
   assign rise = tick && sck_en && !phase;
   assign fall = tick && sck_en && phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
         // phase stays low outside SHIFT so the first tick of SHIFT is always a rise
         if (!sck_en)
            phase <= 1'b0;
         else if (tick)
            phase <= ~phase;
      end
   end

endmodule

// File: rtl/fifo_spi_drain.sv
// Drains a first-word-fall-through byte FIFO through an SPI mode-0 master, MSB first.
// Pop strobe is a same-cycle decode of registered state; CS is held across back-to-back words.
module fifo_spi_drain
   import spi_bridge_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 2,
   parameter int DW      = DEFAULT_DW
) (
   input  logic             i_clk,
   input  logic             i_reset,
   fifo_spi_drain_if.master bus
);

   localparam int BW = $clog2(DW + 1);
   localparam int GW = $clog2(CS_GAP + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'(CS_GAP - 1);

   drain_state_t  state;
   logic [DW-1:0] tx;
   logic [DW-1:0] rx;
   logic [BW-1:0] bit_cnt;
   logic [GW-1:0] gap_cnt;
   logic          div_en, sck_en;
   logic          tick, rise, fall;
   logic          sample_evt, word_end, pop;

   assign div_en = (state == LEAD) || (state == SHIFT) || (state == TRAIL);
   assign sck_en = (state == SHIFT);

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk    (i_clk),
      .rst    (i_reset),
      .en     (div_en),
      .sck_en (sck_en),
      .tick   (tick),
      .rise   (rise),
      .fall   (fall)
   );

   assign sample_evt = (CPHA == 1'b0) ? rise : fall;
   assign word_end   = fall && (bit_cnt == LAST_BIT);

   // Pop only where a word is actually taken: from IDLE, or on the last falling edge of a word
   assign pop = !i_reset && !bus.i_fifo_empty &&
                ((state == IDLE) || ((state == SHIFT) && word_end));
   assign bus.o_fifo_rd = pop;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state          <= IDLE;
         bus.o_cs_n     <= 1'b1;
         bus.o_sck      <= CPOL;
         bus.o_mosi     <= 1'b0;
         bus.o_rx_data  <= '0;
         bus.o_rx_valid <= 1'b0;
         bus.o_busy     <= 1'b0;
         tx             <= '0;
         rx             <= '0;
         bit_cnt        <= '0;
         gap_cnt        <= '0;
      end else begin
         bus.o_rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  tx         <= bus.i_fifo_data;
                  bus.o_mosi <= bus.i_fifo_data[DW-1];
                  bit_cnt    <= '0;
                  bus.o_cs_n <= 1'b0;
                  bus.o_busy <= 1'b1;
                  state      <= LEAD;
               end
            end
            LEAD: begin
               if (tick)
                  state <= SHIFT;
            end
            SHIFT: begin
               if (rise)
                  bus.o_sck <= ~CPOL;
               if (sample_evt)
                  rx <= {rx[DW-2:0], bus.i_miso};
               if (fall) begin
                  bus.o_sck <= CPOL;
                  if (word_end) begin
                     bus.o_rx_data  <= rx;
                     bus.o_rx_valid <= 1'b1;
                     bit_cnt        <= '0;
                     if (pop) begin
                        tx         <= bus.i_fifo_data;
                        bus.o_mosi <= bus.i_fifo_data[DW-1];
                     end else begin
                        state <= TRAIL;
                     end
                  end else begin
                     tx         <= {tx[DW-2:0], 1'b0};
                     bus.o_mosi <= tx[DW-2];
                     bit_cnt    <= bit_cnt + BW'(1);
                  end
               end
            end
            TRAIL: begin
               if (tick) begin
                  bus.o_cs_n <= 1'b1;
                  gap_cnt    <= '0;
                  state      <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == LAST_GAP) begin
                  bus.o_busy <= 1'b0;
                  state      <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
